// File: rtl/imp_sqrt_pkg.sv
// Shared definitions for the iterative integer square-root unit.
package imp_sqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic RND_FLOOR = 1'b0;
    localparam logic RND_NEAR  = 1'b1;

    // The digit-pair recurrence consumes two radicand bits per step,
    // so the radicand width must be even and give at least two steps.
    function automatic bit data_w_ok(input int w);
        return (w >= 4) && ((w % 2) == 0);
    endfunction

endpackage

// File: rtl/imp_sqrt_step.sv
// One restoring digit-by-digit square-root step: brings in the next two
// radicand bits and decides the next root bit.
module imp_sqrt_step #(
    parameter int SQRT_W = 8
) (
    input  logic [SQRT_W+1:0] rem_i,
    input  logic [SQRT_W-1:0] root_i,
    input  logic [1:0]        pair_i,
    output logic [SQRT_W+1:0] rem_o,
    output logic [SQRT_W-1:0] root_o
);

    // One extra bit above {rem, pair} holds the borrow of the trial subtraction.
    localparam int TW = SQRT_W + 5;

    logic [TW-1:0] trial;
    logic [TW-1:0] sub;
    logic [TW-1:0] diff;
    logic          neg;
    logic          unused_bits;

    // Trial subtract {rem, pair} - {root, 01}; keep the difference when it is non-negative.
    always_comb begin
        trial = {1'b0, rem_i, pair_i};
        sub   = {3'b000, root_i, 2'b01};
        diff  = trial - sub;
        neg   = diff[TW-1];
        if (!neg) begin
            rem_o = diff[SQRT_W+1:0];
        end else begin
            rem_o = trial[SQRT_W+1:0];
        end
        root_o = {root_i[SQRT_W-2:0], ~neg};
    end

    // The remainder never exceeds 2*root, so these bits are always zero here,
    // and the partial root's top bit is still zero before every step.
    assign unused_bits = ^{trial[TW-1:SQRT_W+2], diff[TW-2:SQRT_W+2], root_i[SQRT_W-1]};

endmodule

// File: rtl/imp_sqrt_pipe_rnd.sv
// Exact integer square root with floor / round-to-nearest selection and
// valid/ready handshakes on request and result sides.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; a valid source holds its data stable until that edge.
module imp_sqrt_pipe_rnd
    import imp_sqrt_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DATA_W-1:0]   i_data,
    input  logic                i_rnd,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W/2-1:0] o_sqrt,
    output logic                o_sat
);

    localparam int SQRT_W = DATA_W / 2;
    localparam int CNT_W  = $clog2(SQRT_W + 1);

    if (!data_w_ok(DATA_W)) begin : g_bad_width
        $error("imp_sqrt_pipe_rnd: DATA_W must be even and >= 4");
    end

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic                rnd_q, rnd_d;
    logic [SQRT_W+1:0]   rem_q, rem_d;
    logic [SQRT_W-1:0]   root_q, root_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SQRT_W-1:0]   res_q, res_d;
    logic                sat_q, sat_d;

    logic [SQRT_W+1:0]   step_rem;
    logic [SQRT_W-1:0]   step_root;
    logic                round_up;

    imp_sqrt_step #(
        .SQRT_W (SQRT_W)
    ) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .pair_i (opnd_q[DATA_W-1 -: 2]),
        .rem_o  (step_rem),
        .root_o (step_root)
    );

    // rem > root is the same test as x > root^2 + root, i.e. sqrt(x) >= root + 0.5.
    assign round_up = (rnd_q == RND_NEAR) && (rem_q > {2'b00, root_q});

    // Next-state and datapath: accept in IDLE, one root bit per CALC cycle,
    // one ROUND cycle, then hold the result in DONE until it is taken.
    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        rnd_d   = rnd_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    opnd_d  = i_data;
                    rnd_d   = i_rnd;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CNT_W'(SQRT_W);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                opnd_d = {opnd_q[DATA_W-3:0], 2'b00};
                rem_d  = step_rem;
                root_d = step_root;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (round_up && (&root_q)) begin
                    res_d = '1;
                    sat_d = 1'b1;
                end else if (round_up) begin
                    res_d = root_q + SQRT_W'(1);
                    sat_d = 1'b0;
                end else begin
                    res_d = root_q;
                    sat_d = 1'b0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_ready) begin
                    res_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            opnd_q  <= '0;
            rnd_q   <= 1'b0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            rnd_q   <= rnd_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sat_q   <= sat_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_sqrt  = o_valid ? res_q : '0;
    assign o_sat   = o_valid & sat_q;

endmodule

// File: tb/tb_imp_sqrt_pipe_rnd.sv
// Directed and exhaustive checks of the square-root unit at 16- and 8-bit widths.
module tb_imp_sqrt_pipe_rnd;

    logic clk;
    logic rst_n;

    logic        i_valid16, o_ready16, i_rnd16, o_valid16, i_ready16, o_sat16;
    logic [15:0] i_data16;
    logic [7:0]  o_sqrt16;

    logic        i_valid8, o_ready8, i_rnd8, o_valid8, i_ready8, o_sat8;
    logic [7:0]  i_data8;
    logic [3:0]  o_sqrt8;

    int n_cmp;
    int n_err;
    logic [4:0] exp_q[$];

    imp_sqrt_pipe_rnd #(.DATA_W(16)) dut16 (
        .i_clk   (clk),
        .i_rstn  (rst_n),
        .i_valid (i_valid16),
        .o_ready (o_ready16),
        .i_data  (i_data16),
        .i_rnd   (i_rnd16),
        .o_valid (o_valid16),
        .i_ready (i_ready16),
        .o_sqrt  (o_sqrt16),
        .o_sat   (o_sat16)
    );

    imp_sqrt_pipe_rnd #(.DATA_W(8)) dut8 (
        .i_clk   (clk),
        .i_rstn  (rst_n),
        .i_valid (i_valid8),
        .o_ready (o_ready8),
        .i_data  (i_data8),
        .i_rnd   (i_rnd8),
        .o_valid (o_valid8),
        .i_ready (i_ready8),
        .o_sqrt  (o_sqrt8),
        .o_sat   (o_sat8)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request on the 16-bit unit with i_ready high; returns result and latency.
    task automatic req16(input logic [15:0] x, input logic rnd,
                         output logic [7:0] res, output logic sat, output int lat);
        @(negedge clk);
        check("rdy16", 32'(o_ready16), 32'd1);
        i_valid16 = 1'b1;
        i_data16  = x;
        i_rnd16   = rnd;
        @(posedge clk);
        #1;
        i_valid16 = 1'b0;
        lat = 0;
        while (!o_valid16 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        res = o_sqrt16;
        sat = o_sat16;
        @(posedge clk);
        #1;
    endtask

    task automatic req8(input logic [7:0] x, input logic rnd,
                        output logic [3:0] res, output logic sat, output int lat);
        @(negedge clk);
        i_valid8 = 1'b1;
        i_data8  = x;
        i_rnd8   = rnd;
        @(posedge clk);
        #1;
        i_valid8 = 1'b0;
        lat = 0;
        while (!o_valid8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        res = o_sqrt8;
        sat = o_sat8;
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain search for floor root, then the round-to-nearest rule.
    function automatic logic [4:0] model8(input int x, input logic rnd);
        int r;
        logic s;
        r = 0;
        s = 1'b0;
        while ((r + 1) * (r + 1) <= x) r++;
        if (rnd && (x > r * r + r)) begin
            if (r == 15) s = 1'b1;
            else r = r + 1;
        end
        return {s, 4'(r)};
    endfunction

    typedef struct {
        logic [15:0] x;
        logic        rnd;
        logic [7:0]  res;
        logic        sat;
    } vec_t;

    initial begin
        vec_t vecs[8];
        logic [7:0] r16;
        logic [3:0] r8;
        logic       s;
        int         lat;
        logic       seen;
        logic [4:0] e;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        i_valid16 = 1'b0; i_data16 = '0; i_rnd16 = 1'b0; i_ready16 = 1'b1;
        i_valid8  = 1'b0; i_data8  = '0; i_rnd8  = 1'b0; i_ready8  = 1'b1;

        vecs[0] = '{16'd0,     1'b0, 8'd0,   1'b0};
        vecs[1] = '{16'd0,     1'b1, 8'd0,   1'b0};
        vecs[2] = '{16'd56,    1'b1, 8'd7,   1'b0};
        vecs[3] = '{16'd57,    1'b1, 8'd8,   1'b0};
        vecs[4] = '{16'd57,    1'b0, 8'd7,   1'b0};
        vecs[5] = '{16'd65535, 1'b0, 8'd255, 1'b0};
        vecs[6] = '{16'd65535, 1'b1, 8'd255, 1'b1};
        vecs[7] = '{16'd65025, 1'b1, 8'd255, 1'b0};

        // reset state
        #12;
        check("rst_ready",  32'(o_ready16), 32'd1);
        check("rst_valid",  32'(o_valid16), 32'd0);
        check("rst_sqrt",   32'(o_sqrt16),  32'd0);
        check("rst_sat",    32'(o_sat16),   32'd0);
        check("rst_ready8", 32'(o_ready8),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // directed vectors, 16-bit
        foreach (vecs[i]) begin
            req16(vecs[i].x, vecs[i].rnd, r16, s, lat);
            check($sformatf("sqrt16_%0d_r%0d", vecs[i].x, vecs[i].rnd), 32'(r16), 32'(vecs[i].res));
            check($sformatf("sat16_%0d_r%0d", vecs[i].x, vecs[i].rnd), 32'(s), 32'(vecs[i].sat));
            check($sformatf("lat16_%0d", i), 32'(lat), 32'd9);
        end

        // back-pressure: x=1000 round -> 32, held 5 cycles with a pending request
        i_ready16 = 1'b0;
        @(negedge clk);
        i_valid16 = 1'b1; i_data16 = 16'd1000; i_rnd16 = 1'b1;
        @(posedge clk);
        #1;
        check("bp_busy", 32'(o_ready16), 32'd0);
        i_valid16 = 1'b0;
        lat = 0;
        while (!o_valid16 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd9);
        i_valid16 = 1'b1; i_data16 = 16'd144; i_rnd16 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(o_valid16), 32'd1);
            check("bp_sqrt",  32'(o_sqrt16),  32'd32);
            check("bp_ready", 32'(o_ready16), 32'd0);
        end
        i_ready16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_relvalid", 32'(o_valid16), 32'd0);
        check("bp_relready", 32'(o_ready16), 32'd1);
        @(posedge clk);
        #1;
        i_valid16 = 1'b0;
        check("bp_accept", 32'(o_ready16), 32'd0);
        lat = 0;
        while (!o_valid16 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp2_lat", 32'(lat), 32'd9);
        @(negedge clk);
        check("bp2_sqrt", 32'(o_sqrt16), 32'd12);
        @(posedge clk);
        #1;

        // reset in the 4th CALC cycle aborts the request
        @(negedge clk);
        i_valid16 = 1'b1; i_data16 = 16'd5000; i_rnd16 = 1'b0;
        @(posedge clk);
        #1;
        i_valid16 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(o_ready16), 32'd1);
        check("abort_valid", 32'(o_valid16), 32'd0);
        check("abort_sqrt",  32'(o_sqrt16),  32'd0);
        check("abort_sat",   32'(o_sat16),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (o_valid16) seen = 1'b1;
        end
        check("abort_noval", 32'(seen), 32'd0);
        req16(16'd144, 1'b1, r16, s, lat);
        check("post_abort_sqrt", 32'(r16), 32'd12);
        check("post_abort_lat",  32'(lat), 32'd9);

        // 8-bit unit: saturation corner and latency
        req8(8'd255, 1'b1, r8, s, lat);
        check("sqrt8_255", 32'(r8),  32'd15);
        check("sat8_255",  32'(s),   32'd1);
        check("lat8",      32'(lat), 32'd5);

        // 8-bit exhaustive sweep against the reference model, random mode order
        for (int m = 0; m < 2; m++) begin
            logic first_mode;
            first_mode = 1'($urandom_range(0, 1));
            for (int x = 0; x < 256; x++) begin
                exp_q.push_back(model8(x, first_mode ^ m[0]));
                req8(8'(x), first_mode ^ m[0], r8, s, lat);
                e = exp_q.pop_front();
                check($sformatf("sweep8_%0d_r%0d", x, first_mode ^ m[0]), 32'({s, r8}), 32'(e));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imp_sqrt_pipe_rnd.md
Name: imp_sqrt_pipe_rnd

Overview:
Parametrised, exact integer square-root unit for the normalisation datapath. It replaces the fixed 16-bit LUT-based root with a digit-by-digit iterative root that is exact at any even input width. Each request selects floor or round-to-nearest. A valid/ready handshake on both sides allows back-pressure from the downstream scaling stage. It sits between the variance accumulator and the reciprocal/scale stage.

Parameters:
DATA_W, 16, input width in bits; must be even and ≥ 4.
SQRT_W, DATA_W/2, root width (derived localparam, not overridable).
CNT_W, $clog2(SQRT_W+1), iteration-counter width (derived).

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_valid  in  1  request valid
o_ready  out  1  unit can accept a request (high only in IDLE)
i_data  in  DATA_W  unsigned radicand
i_rnd  in  1  rounding mode: 0 = floor, 1 = round-to-nearest
o_valid  out  1  result valid; held until accepted
i_ready  in  1  downstream accepts result
o_sqrt  out  SQRT_W  result; 0 whenever o_valid = 0
o_sat  out  1  round-to-nearest overflowed SQRT_W and was clamped; 0 whenever o_valid = 0

Behaviour:
- Clock is i_clk. Reset i_rstn is asynchronous, active-low.
- Reset values: state = IDLE, o_ready = 1, o_valid = 0, o_sqrt = 0, o_sat = 0, and all internal registers = 0.
- FSM states are IDLE, CALC, ROUND and DONE.
- IDLE:
  - o_ready = 1.
  - Accept occurs when i_valid & o_ready. On accept, latch i_data into the operand shift register and latch i_rnd.
  - Clear root and remainder, load counter = SQRT_W, then go to CALC.
- CALC, one root bit per cycle for SQRT_W cycles:
  - Take the next two MSBs of the operand (operand shifts left by 2).
  - Compute t = {rem, 2 bits} − {root, 2'b01}. The remainder register is SQRT_W+2 bits wide.
  - If t ≥ 0: rem = t, root = {root, 1}. Otherwise: rem = {rem, 2 bits}, root = {root, 0}.
  - Decrement the counter. When the counter reaches 1, go to ROUND.
  - At the end of CALC, root = floor(sqrt(x)) and rem = x − root², with 0 ≤ rem ≤ 2·root.
- ROUND, one cycle:
  - Floor mode: result = root.
  - Round mode: round up iff rem > root, which is equivalent to x > root² + root.
  - If rounding up and root is all-ones: result = all-ones and sat = 1. Otherwise result = root + 1.
  - sat = 0 in every other case.
  - Go to DONE.
- DONE:
  - o_valid = 1. o_sqrt and o_sat are driven from the registered result.
  - When i_ready = 1: go to IDLE, clear the result registers.
  - When i_ready = 0: stay in DONE with the outputs stable (no change while stalled).
- Latency: fixed at SQRT_W+1 clock edges from the accept edge to o_valid high (9 for DATA_W = 16).
  - No data-dependent early exit, including for x = 0.
- Throughput: one request per SQRT_W+3 cycles when i_ready is held high.
- Requests during CALC, ROUND or DONE are not accepted (o_ready = 0). The upstream must hold i_valid.
- Result acceptance and new-request acceptance never occur in the same cycle.
- Reset asserted mid-operation aborts immediately to the reset values. No result is emitted for the aborted request.
- x = 0 gives 0 in both modes with sat = 0.

Decomposition:
- Shared package imp_sqrt_pkg:
  - state encodings ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_ROUND = 2'd2, ST_DONE = 2'd3;
  - RND_FLOOR = 1'b0 and RND_NEAR = 1'b1;
  - a width-check function for the even-DATA_W assertion.
- One combinational sub-module imp_sqrt_step (parameter SQRT_W). It takes rem, root and the 2-bit digit pair, and returns the next rem and root.
- The top level holds the FSM, the counter, the handshake logic and the rounding logic.

Test Plan:
- DATA_W = 16, x = 0 in both modes → o_sqrt = 0, o_sat = 0, o_valid exactly 9 cycles after accept.
- x = 56, i_rnd = 1 → 7 (56 = 7² + 7, no round-up). x = 57, i_rnd = 1 → 8. x = 57, i_rnd = 0 → 7.
- x = 65535: i_rnd = 0 → 255, o_sat = 0. i_rnd = 1 → 255, o_sat = 1. x = 65025, i_rnd = 1 → 255, o_sat = 0.
- Back-pressure with x = 1000, i_rnd = 1 (result 32): hold i_ready = 0 for 5 cycles → o_valid and o_sqrt = 32 stay stable; o_ready stays 0; a pending i_valid is not accepted until one cycle after the i_ready handshake.
- Reset pulse in the 4th CALC cycle → all outputs return to reset values immediately, o_valid never rises. The next request x = 144 → 12.
- DATA_W = 8: x = 255, i_rnd = 1 → 15 with o_sat = 1, latency 5. Random sweep of all 256 inputs against a floor/round reference model in both modes.
